// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter: buffers three register-write sources in FIFOs and round-robins them onto one write port.
// Optional REGFILE_WB_ARB_STATS_EN adds saturating write and conflict counters.
module regfile_writeback_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4,
    parameter int NUM_REGS   = 2**SEL_WIDTH,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_flush,
    input  logic [2:0]              in_src_valid,
    output logic [2:0]              out_src_ready,
    input  logic [3*SEL_WIDTH-1:0]  in_src_sel,
    input  logic [3*DATA_WIDTH-1:0] in_src_data,
    output logic                    out_write_en,
    output logic [SEL_WIDTH-1:0]    out_write_sel,
    output logic [DATA_WIDTH-1:0]   out_write_data,
    output logic [NUM_REGS-1:0]     out_pending_mask,
    output logic                    out_idle
`ifdef REGFILE_WB_ARB_STATS_EN
    ,
    output logic [31:0]             out_stat_writes,
    output logic [31:0]             out_stat_conflicts
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [SEL_WIDTH-1:0]  sel_q  [3][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_q [3][FIFO_DEPTH];
    logic [PW-1:0]         wr_q [3];
    logic [PW-1:0]         rd_q [3];
    logic [1:0]            last_q, gnt, cand;
    logic                  any_gnt, load;
    logic [2:0]            empty, full, push;
    logic                  en_q;
    logic [SEL_WIDTH-1:0]  wsel_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NUM_REGS-1:0]   mask;

    always_comb begin
        empty = '0;
        full  = '0;
        push  = '0;
        for (int i = 0; i < 3; i++) begin
            empty[i] = wr_q[i] == rd_q[i];
            full[i]  = (wr_q[i][PW-1] != rd_q[i][PW-1]) && (wr_q[i][AW-1:0] == rd_q[i][AW-1:0]);
            // r0 requests are handshaken but never stored
            push[i]  = in_src_valid[i] && !full[i] && !in_flush
                       && (in_src_sel[i*SEL_WIDTH +: SEL_WIDTH] != '0);
        end
    end

    always_comb begin
        gnt     = last_q;
        cand    = last_q;
        any_gnt = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            cand = 2'((int'(last_q) + k) % 3);
            if (!any_gnt && !empty[cand]) begin
                gnt     = cand;
                any_gnt = 1'b1;
            end
        end
    end

    assign load = any_gnt && !in_flush;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push[i]) begin
                sel_q[i][wr_q[i][AW-1:0]]  <= in_src_sel[i*SEL_WIDTH +: SEL_WIDTH];
                data_q[i][wr_q[i][AW-1:0]] <= in_src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                wr_q[i] <= '0;
                rd_q[i] <= '0;
            end
        end else if (in_flush) begin
            for (int i = 0; i < 3; i++) begin
                wr_q[i] <= '0;
                rd_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (push[i]) wr_q[i] <= wr_q[i] + 1'b1;
                if (any_gnt && gnt == 2'(i)) rd_q[i] <= rd_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            wsel_q  <= '0;
            wdata_q <= '0;
            last_q  <= 2'd2;
        end else begin
            en_q <= load;
            if (load) begin
                wsel_q  <= sel_q[gnt][rd_q[gnt][AW-1:0]];
                wdata_q <= data_q[gnt][rd_q[gnt][AW-1:0]];
                last_q  <= gnt;
            end
        end
    end

    // a slot is live when its distance from the read pointer is below the occupancy
    always_comb begin
        mask = '0;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                if ({1'b0, AW'(k) - rd_q[i][AW-1:0]} < (wr_q[i] - rd_q[i])) mask[sel_q[i][k]] = 1'b1;
            end
        end
        if (en_q) mask[wsel_q] = 1'b1;
        mask[0] = 1'b0;
    end

    assign out_src_ready    = ~full;
    assign out_write_en     = en_q;
    assign out_write_sel    = wsel_q;
    assign out_write_data   = wdata_q;
    assign out_pending_mask = mask;
    assign out_idle         = (&empty) && !en_q;

`ifdef REGFILE_WB_ARB_STATS_EN
    logic [31:0] stat_wr_q, stat_cf_q;
    logic        conflict;

    assign conflict = (!empty[0] && !empty[1]) || (!empty[0] && !empty[2]) || (!empty[1] && !empty[2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_wr_q <= '0;
            stat_cf_q <= '0;
        end else begin
            if (en_q && stat_wr_q != '1) stat_wr_q <= stat_wr_q + 1'b1;
            if (conflict && !in_flush && stat_cf_q != '1) stat_cf_q <= stat_cf_q + 1'b1;
        end
    end

    assign out_stat_writes    = stat_wr_q;
    assign out_stat_conflicts = stat_cf_q;
`endif
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// tb_regfile_writeback_arbiter: vector table, reset corner case and queue-model random run for the writeback arbiter.
module tb_regfile_writeback_arbiter;
    localparam int DEPTH = 2;
    localparam logic [31:0] DA = 32'hA1;
    localparam logic [31:0] DB = 32'hB2;

    logic        clk, rst_n, in_flush;
    logic [2:0]  in_src_valid, out_src_ready;
    logic [11:0] in_src_sel;
    logic [95:0] in_src_data;
    logic        out_write_en, out_idle;
    logic [3:0]  out_write_sel;
    logic [31:0] out_write_data;
    logic [15:0] out_pending_mask;
`ifdef REGFILE_WB_ARB_STATS_EN
    logic [31:0] out_stat_writes, out_stat_conflicts;
`endif

    regfile_writeback_arbiter dut (
        .clk(clk), .rst_n(rst_n), .in_flush(in_flush),
        .in_src_valid(in_src_valid), .out_src_ready(out_src_ready),
        .in_src_sel(in_src_sel), .in_src_data(in_src_data),
        .out_write_en(out_write_en), .out_write_sel(out_write_sel),
        .out_write_data(out_write_data), .out_pending_mask(out_pending_mask),
        .out_idle(out_idle)
`ifdef REGFILE_WB_ARB_STATS_EN
        , .out_stat_writes(out_stat_writes), .out_stat_conflicts(out_stat_conflicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  v;
        logic [3:0]  s0, s1, s2;
        logic [31:0] d0, d1, d2;
        logic        fl;
        logic        e_en;
        logic [3:0]  e_sel;
        logic [31:0] e_data;
        logic [15:0] e_mask;
        logic [2:0]  e_rdy;
        logic        e_idle;
    } vec_t;

    vec_t tbl [27];
    int n_chk = 0;
    int n_fail = 0;

    logic [3:0]  mq_s [3][$];
    logic [31:0] mq_d [3][$];
    int          m_lg;
    logic        m_en;
    logic [3:0]  m_sel;
    logic [31:0] m_data;

    function automatic vec_t mk(logic [2:0] v, logic [3:0] s0, logic [3:0] s1, logic [3:0] s2,
                                logic [31:0] d0, logic [31:0] d1, logic [31:0] d2, logic fl,
                                logic e_en, logic [3:0] e_sel, logic [31:0] e_data,
                                logic [15:0] e_mask, logic [2:0] e_rdy, logic e_idle);
        vec_t r;
        r.v = v; r.s0 = s0; r.s1 = s1; r.s2 = s2; r.d0 = d0; r.d1 = d1; r.d2 = d2; r.fl = fl;
        r.e_en = e_en; r.e_sel = e_sel; r.e_data = e_data; r.e_mask = e_mask; r.e_rdy = e_rdy; r.e_idle = e_idle;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2, input logic fl);
        in_src_valid = v;
        in_src_sel   = {s2, s1, s0};
        in_src_data  = {d2, d1, d0};
        in_flush     = fl;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq_s[i].delete();
            mq_d[i].delete();
        end
        m_lg = 2; m_en = 1'b0; m_sel = '0; m_data = '0;
    endtask

    task automatic model_edge(input logic [2:0] v, input logic [11:0] s, input logic [95:0] d, input logic fl);
        bit rdy [3];
        int g;
        int c;
        for (int i = 0; i < 3; i++) rdy[i] = mq_s[i].size() < DEPTH;
        if (fl) begin
            for (int i = 0; i < 3; i++) begin
                mq_s[i].delete();
                mq_d[i].delete();
            end
            m_en = 1'b0;
        end else begin
            g = -1;
            for (int k = 1; k <= 3; k++) begin
                c = (m_lg + k) % 3;
                if (g < 0 && mq_s[c].size() > 0) g = c;
            end
            if (g >= 0) begin
                m_en = 1'b1;
                m_sel = mq_s[g].pop_front();
                m_data = mq_d[g].pop_front();
                m_lg = g;
            end else m_en = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (v[i] && rdy[i] && s[i*4 +: 4] != 4'd0) begin
                    mq_s[i].push_back(s[i*4 +: 4]);
                    mq_d[i].push_back(d[i*32 +: 32]);
                end
            end
        end
    endtask

    task automatic model_check(input int cyc);
        logic [15:0] m;
        logic [2:0]  r;
        bit          idle;
        m = '0;
        idle = !m_en;
        for (int i = 0; i < 3; i++) begin
            foreach (mq_s[i][j]) m[mq_s[i][j]] = 1'b1;
            r[i] = mq_s[i].size() < DEPTH;
            if (mq_s[i].size() != 0) idle = 1'b0;
        end
        if (m_en) m[m_sel] = 1'b1;
        m[0] = 1'b0;
        chk($sformatf("rnd%0d.en", cyc), 32'(out_write_en), 32'(m_en));
        if (m_en) begin
            chk($sformatf("rnd%0d.sel", cyc), 32'(out_write_sel), 32'(m_sel));
            chk($sformatf("rnd%0d.data", cyc), out_write_data, m_data);
        end
        chk($sformatf("rnd%0d.mask", cyc), 32'(out_pending_mask), 32'(m));
        chk($sformatf("rnd%0d.rdy", cyc), 32'(out_src_ready), 32'(r));
        chk($sformatf("rnd%0d.idle", cyc), 32'(out_idle), 32'(idle));
    endtask

    initial begin
        tbl[0]  = mk(3'b111, 1, 2, 3, DA, DB, 32'hC3, 0,  0, 0, 0,            16'h000E, 3'b111, 0);
        tbl[1]  = mk(3'b111, 1, 2, 3, DA, DB, 32'hC3, 0,  1, 1, DA,           16'h000E, 3'b001, 0);
        tbl[2]  = mk(3'b111, 1, 2, 3, DA, DB, 32'hC3, 0,  1, 2, DB,           16'h000E, 3'b010, 0);
        tbl[3]  = mk(3'b111, 1, 2, 3, DA, DB, 32'hC3, 0,  1, 3, 32'hC3,       16'h000E, 3'b100, 0);
        tbl[4]  = mk(3'b111, 1, 2, 3, DA, DB, 32'hC3, 0,  1, 1, DA,           16'h000E, 3'b001, 0);
        tbl[5]  = mk(3'b111, 1, 2, 3, DA, DB, 32'hC3, 0,  1, 2, DB,           16'h000E, 3'b010, 0);
        tbl[6]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 1,         0, 0, 0,            16'h0000, 3'b111, 1);
        tbl[7]  = mk(3'b010, 0, 5, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0,         16'h0020, 3'b111, 0);
        tbl[8]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0,         1, 5, 32'hDEADBEEF, 16'h0020, 3'b111, 0);
        tbl[9]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0,         0, 0, 0,            16'h0000, 3'b111, 1);
        tbl[10] = mk(3'b001, 0, 0, 0, 32'h1234, 0, 0, 0,  0, 0, 0,            16'h0000, 3'b111, 1);
        tbl[11] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0,         0, 0, 0,            16'h0000, 3'b111, 1);
        tbl[12] = mk(3'b101, 4, 0, 6, 32'hD4, 0, 32'hE6, 0, 0, 0, 0,          16'h0050, 3'b111, 0);
        tbl[13] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0,         1, 6, 32'hE6,       16'h0050, 3'b111, 0);
        tbl[14] = mk(3'b000, 0, 0, 0, 0, 0, 0, 1,         0, 0, 0,            16'h0000, 3'b111, 1);
        tbl[15] = mk(3'b111, 1, 2, 7, DA, DB, 32'hC7, 0,  0, 0, 0,            16'h0086, 3'b111, 0);
        tbl[16] = mk(3'b111, 1, 2, 8, DA, DB, 32'hC8, 0,  1, 1, DA,           16'h0186, 3'b001, 0);
        tbl[17] = mk(3'b111, 1, 2, 9, DA, DB, 32'hC9, 0,  1, 2, DB,           16'h0186, 3'b010, 0);
        tbl[18] = mk(3'b111, 1, 2, 9, DA, DB, 32'hC9, 0,  1, 7, 32'hC7,       16'h0186, 3'b100, 0);
        tbl[19] = mk(3'b111, 1, 2, 9, DA, DB, 32'hC9, 0,  1, 1, DA,           16'h0306, 3'b001, 0);
        tbl[20] = mk(3'b011, 1, 2, 0, DA, DB, 0, 0,       1, 2, DB,           16'h0306, 3'b010, 0);
        tbl[21] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0,         1, 8, 32'hC8,       16'h0306, 3'b110, 0);
        tbl[22] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0,         1, 1, DA,           16'h0206, 3'b111, 0);
        tbl[23] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0,         1, 2, DB,           16'h0206, 3'b111, 0);
        tbl[24] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0,         1, 9, 32'hC9,       16'h0202, 3'b111, 0);
        tbl[25] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0,         1, 1, DA,           16'h0002, 3'b111, 0);
        tbl[26] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0,         0, 0, 0,            16'h0000, 3'b111, 1);

        rst_n = 1'b0;
        drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b0);
        #1;
        chk("rst.en", 32'(out_write_en), 32'd0);
        chk("rst.sel", 32'(out_write_sel), 32'd0);
        chk("rst.data", out_write_data, 32'd0);
        chk("rst.mask", 32'(out_pending_mask), 32'd0);
        chk("rst.idle", 32'(out_idle), 32'd1);
        chk("rst.rdy", 32'(out_src_ready), 32'd7);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].v, tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].fl);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.en", i), 32'(out_write_en), 32'(tbl[i].e_en));
            if (tbl[i].e_en) begin
                chk($sformatf("vec%0d.sel", i), 32'(out_write_sel), 32'(tbl[i].e_sel));
                chk($sformatf("vec%0d.data", i), out_write_data, tbl[i].e_data);
            end
            chk($sformatf("vec%0d.mask", i), 32'(out_pending_mask), 32'(tbl[i].e_mask));
            chk($sformatf("vec%0d.rdy", i), 32'(out_src_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d.idle", i), 32'(out_idle), 32'(tbl[i].e_idle));
        end

        // asynchronous reset in the middle of a three-way burst
        drive(3'b111, 1, 2, 3, DA, DB, 32'hC3, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("arst.pre_en", 32'(out_write_en), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst.en", 32'(out_write_en), 32'd0);
        chk("arst.mask", 32'(out_pending_mask), 32'd0);
        chk("arst.idle", 32'(out_idle), 32'd1);
        chk("arst.rdy", 32'(out_src_ready), 32'd7);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst.fill_en", 32'(out_write_en), 32'd0);
        @(posedge clk); #1;
        chk("arst.first_en", 32'(out_write_en), 32'd1);
        chk("arst.first_sel", 32'(out_write_sel), 32'd1);
        chk("arst.first_data", out_write_data, DA);
        drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b1);
        @(posedge clk); #1;

        rst_n = 1'b0;
        drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b0);
        #2 rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [2:0]  v;
            logic [11:0] s;
            logic [95:0] d;
            logic        fl;
            v  = 3'($urandom_range(0, 7) | $urandom_range(0, 7));
            s  = 12'($urandom);
            d  = {$urandom, $urandom, $urandom};
            fl = ($urandom_range(0, 24) == 0);
            drive(v, s[3:0], s[7:4], s[11:8], d[31:0], d[63:32], d[95:64], fl);
            @(posedge clk);
            model_edge(v, s, d, fl);
            #1;
            model_check(c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
